v_rams_pipe_reader: RTL and testbench

V_RAMS_PIPE_READER -- requirements
Module: v_rams_pipe_reader

---
 rtl/v_rams_pipe_reader_pkg.sv | 13 +
 rtl/v_rams_pipe_reader_fifo.sv | 75 +++++++
 rtl/v_rams_pipe_reader.sv | 125 ++++++++++++
 tb/tb_v_rams_pipe_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/v_rams_pipe_reader_pkg.sv
// Shared types and constants for the pipelined RAM burst reader.
package v_rams_pipe_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned RD_LAT_C   = 2;

endpackage

// File: rtl/v_rams_pipe_reader_fifo.sv
// 4-entry output FIFO with fall-through: a word arriving while the FIFO is
// empty is presented immediately and only stored if the consumer stalls.
module v_rams_pipe_reader_fifo
    import v_rams_pipe_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [2:0]       count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;
    logic             empty;
    logic             store;
    logic             pop;

    assign count = count_q;

    // Presentation, bypass decision and next-state of pointers/storage.
    always_comb begin
        empty    = (count_q == 3'd0);
        rd_valid = !empty || wr_en;
        rd_data  = empty ? wr_data : mem_q[rd_ptr_q];
        // A word consumed straight off the bypass path is never stored.
        store    = wr_en && !(empty && rd_ready);
        pop      = rd_ready && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (store) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (store && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!store && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/v_rams_pipe_reader.sv
// Burst reader: issues sequential reads to a 2-cycle-latency RAM, keeps
// in-flight + buffered words within the FIFO depth, and streams the words
// out on a valid/ready interface with a last marker and a done pulse.
module v_rams_pipe_reader
    import v_rams_pipe_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned RD_LAT = RD_LAT_C
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_do,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic              done_q, done_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] lst_q, lst_d;

    logic [2:0]        inflight;
    logic [2:0]        fifo_count;
    logic              fifo_valid;
    logic [DATA_W:0]   fifo_data;
    logic              room;
    logic              issue;
    logic              final_issue;

    assign ram_we    = 1'b0;
    assign ram_addr  = addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign out_valid = fifo_valid;
    assign out_data  = fifo_data[DATA_W-1:0];
    assign out_last  = fifo_valid && fifo_data[DATA_W];

    v_rams_pipe_reader_fifo #(
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (vld_q[RD_LAT-1]),
        .wr_data  ({lst_q[RD_LAT-1], ram_do}),
        .rd_ready (out_ready),
        .rd_valid (fifo_valid),
        .rd_data  (fifo_data),
        .count    (fifo_count)
    );

    // Read issue throttling, return tracking and burst FSM next-state.
    always_comb begin
        inflight    = {2'b00, vld_q[0]} + {2'b00, vld_q[1]};
        room        = ({1'b0, inflight} + {1'b0, fifo_count}) < 4'(FIFO_DEPTH);
        issue       = (state_q == ST_RUN) && room;
        final_issue = issue && (remain_q == {{ADDR_W{1'b0}}, 1'b1});
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        done_d      = 1'b0;
        vld_d       = {vld_q[RD_LAT-2:0], issue};
        lst_d       = {lst_q[RD_LAT-2:0], final_issue};
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        addr_d   = base_addr;
                        remain_d = len;
                        state_d  = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (final_issue) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_valid && out_ready && fifo_data[DATA_W]) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, address, counters and read-return shift registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            done_q   <= 1'b0;
            vld_q    <= '0;
            lst_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            done_q   <= done_d;
            vld_q    <= vld_d;
            lst_q    <= lst_d;
        end
    end

endmodule

// File: tb/tb_v_rams_pipe_reader.sv
// Self-checking bench for v_rams_pipe_reader with a behavioural RAM.
module tb_v_rams_pipe_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [8:0] base_addr;
    logic [9:0] len;
    logic       busy, done, ram_we;
    logic [8:0] ram_addr;
    logic [3:0] ram_do;
    logic       out_valid, out_ready;
    logic [3:0] out_data;
    logic       out_last;

    always #5 clk = ~clk;

    v_rams_pipe_reader #(.ADDR_W(9), .DATA_W(4), .RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .ram_we(ram_we), .ram_addr(ram_addr), .ram_do(ram_do),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    // Two-cycle read latency RAM model.
    logic [3:0] ram [512];
    logic [3:0] p1;
    always @(posedge clk) begin
        p1     <= ram[ram_addr];
        ram_do <= p1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] got_data[$];
    bit         got_last[$];
    int         got_cyc[$];
    int         done_cyc[$];
    bit         busy_at_done[$];
    int         max_out;
    int         stab_err;
    bit         saw_busy, saw_valid, timed_out;

    function automatic logic pick_ready(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 2 && c >= 8 && c < 18) return 1'b0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Starts one burst in cycle 0 and records everything observed until a
    // few cycles after done (or the cycle budget runs out).
    task automatic burst(input logic [8:0] b, input int l, input int mode,
                         input int maxc, input bit second);
        int c, tail, iss, outst;
        logic [8:0] d9;
        logic prev_stall;
        logic [3:0] prev_data;
        got_data.delete(); got_last.delete(); got_cyc.delete();
        done_cyc.delete(); busy_at_done.delete();
        max_out = 0; stab_err = 0; saw_busy = 0; saw_valid = 0; timed_out = 0;
        prev_stall = 0; prev_data = '0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = 10'(l); out_ready = pick_ready(mode, 0);
        c = 0; tail = -1;
        forever begin
            @(negedge clk);
            if (busy && c >= 1 && l < 512) begin
                d9 = ram_addr - b;
                iss = int'(d9);
                outst = iss - got_data.size();
                if (outst > max_out) max_out = outst;
            end
            if (prev_stall && (!out_valid || out_data !== prev_data)) stab_err++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (busy) saw_busy = 1;
            if (out_valid) saw_valid = 1;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                got_cyc.push_back(c);
            end
            if (done) begin
                done_cyc.push_back(c);
                busy_at_done.push_back(busy);
                if (tail < 0) tail = c + 8;
            end
            if (c == tail) break;
            if (c == maxc) begin
                timed_out = 1;
                break;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (second && c == 1) begin
                start = 1'b1; base_addr = b + 9'd100; len = 10'd7;
            end
            out_ready = pick_ready(mode, c + 1);
            c++;
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got %b want 0", out_last); end
        n_cmp++; if (ram_addr !== 9'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", ram_addr); end
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", ram_we); end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_basic();
        burst(9'd5, 4, 0, 60, 0);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL basic_timeout got 1 want 0"); end
        n_cmp++; if (got_data.size() != 4) begin n_bad++; $display("FAIL basic_count got %0d want 4", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            n_cmp++; if (got_data[i] !== 4'(5 + i)) begin n_bad++; $display("FAIL basic_data[%0d] got %0d want %0d", i, got_data[i], 5 + i); end
            n_cmp++; if (got_cyc[i] != 3 + i) begin n_bad++; $display("FAIL basic_cycle[%0d] got %0d want %0d", i, got_cyc[i], 3 + i); end
            n_cmp++; if (got_last[i] !== (i == 3)) begin n_bad++; $display("FAIL basic_last[%0d] got %b want %b", i, got_last[i], i == 3); end
        end
        n_cmp++; if (done_cyc.size() != 1) begin n_bad++; $display("FAIL basic_done_count got %0d want 1", done_cyc.size()); end
        if (done_cyc.size() >= 1) begin
            n_cmp++; if (done_cyc[0] != 7) begin n_bad++; $display("FAIL basic_done_cycle got %0d want 7", done_cyc[0]); end
            n_cmp++; if (busy_at_done[0] !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", busy_at_done[0]); end
        end
    endtask

    task automatic test_wrap();
        logic [8:0] seen[$];
        logic [8:0] exp_a;
        for (int i = 0; i < 512; i++) ram[i] = 4'($urandom);
        fork
            burst(9'd510, 4, 0, 60, 0);
            begin
                repeat (12) begin
                    @(negedge clk);
                    if (busy && (seen.size() == 0 || seen[$] !== ram_addr)) seen.push_back(ram_addr);
                end
            end
        join
        for (int i = 0; i < 4; i++) begin
            exp_a = 9'(510 + i);
            n_cmp++; if (seen.size() <= i || seen[i] !== exp_a) begin n_bad++; $display("FAIL wrap_addr[%0d] got %0d want %0d", i, (seen.size() > i) ? seen[i] : 9'h1FF, exp_a); end
        end
        n_cmp++; if (got_data.size() != 4) begin n_bad++; $display("FAIL wrap_count got %0d want 4", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            exp_a = 9'(510 + i);
            n_cmp++; if (got_data[i] !== ram[exp_a]) begin n_bad++; $display("FAIL wrap_data[%0d] got %0d want %0d", i, got_data[i], ram[exp_a]); end
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] b;
        logic [8:0] a;
        int errs;
        b = 9'($urandom);
        burst(b, 16, 2, 400, 0);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL bp_timeout got 1 want 0"); end
        n_cmp++; if (got_data.size() != 16) begin n_bad++; $display("FAIL bp_count got %0d want 16", got_data.size()); end
        errs = 0;
        for (int i = 0; i < got_data.size() && i < 16; i++) begin
            a = b + 9'(i);
            if (got_data[i] !== ram[a] || got_last[i] !== (i == 15)) errs++;
        end
        n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL bp_order got %0d bad words want 0", errs); end
        n_cmp++; if (max_out > 4) begin n_bad++; $display("FAIL bp_outstanding got %0d want <=4", max_out); end
        n_cmp++; if (stab_err != 0) begin n_bad++; $display("FAIL bp_stable got %0d changes want 0", stab_err); end
        n_cmp++; if (done_cyc.size() != 1) begin n_bad++; $display("FAIL bp_done_count got %0d want 1", done_cyc.size()); end
    endtask

    task automatic test_zero_len();
        burst(9'($urandom), 0, 0, 30, 0);
        n_cmp++; if (done_cyc.size() != 1 || done_cyc[0] != 1) begin n_bad++; $display("FAIL zero_done got %0d pulses want 1 at cycle 1", done_cyc.size()); end
        n_cmp++; if (saw_valid) begin n_bad++; $display("FAIL zero_valid got 1 want 0"); end
        n_cmp++; if (saw_busy) begin n_bad++; $display("FAIL zero_busy got 1 want 0"); end
    endtask

    task automatic test_reset_mid();
        int words, cyc;
        bit noisy;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 9'($urandom); len = 10'd10; out_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        words = 0; cyc = 0;
        while (words < 3 && cyc < 40) begin
            @(negedge clk);
            if (out_valid && out_ready) words++;
            cyc++;
        end
        n_cmp++; if (words != 3) begin n_bad++; $display("FAIL rstmid_words got %0d want 3", words); end
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0 || ram_addr !== 9'd0)
        begin n_bad++; $display("FAIL rstmid_zero got busy=%b valid=%b last=%b done=%b addr=%0d want all 0", busy, out_valid, out_last, done, ram_addr); end
        noisy = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid || done || busy) noisy = 1;
        end
        n_cmp++; if (noisy) begin n_bad++; $display("FAIL rstmid_quiet got activity want none"); end
        burst(9'd0, 2, 0, 60, 0);
        n_cmp++; if (got_data.size() != 2) begin n_bad++; $display("FAIL rstmid_count got %0d want 2", got_data.size()); end
        if (got_data.size() >= 2) begin
            n_cmp++; if (got_data[0] !== ram[0] || got_data[1] !== ram[1] || got_last[1] !== 1'b1)
            begin n_bad++; $display("FAIL rstmid_data got %0d,%0d last=%b want %0d,%0d last=1", got_data[0], got_data[1], got_last[1], ram[0], ram[1]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] b;
        logic [8:0] a;
        int errs, lasts;
        for (int i = 0; i < 512; i++) ram[i] = 4'($urandom);
        b = 9'($urandom);
        burst(b, 512, 1, 3000, 1);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL b2b_timeout got 1 want 0"); end
        n_cmp++; if (got_data.size() != 512) begin n_bad++; $display("FAIL b2b_count got %0d want 512", got_data.size()); end
        errs = 0; lasts = 0;
        for (int i = 0; i < got_data.size() && i < 512; i++) begin
            a = b + 9'(i);
            if (got_data[i] !== ram[a]) errs++;
            if (got_last[i]) lasts++;
        end
        n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL b2b_order got %0d bad words want 0", errs); end
        n_cmp++; if (lasts != 1 || got_data.size() != 512 || got_last[511] !== 1'b1) begin n_bad++; $display("FAIL b2b_last got %0d last flags want 1 on word 512", lasts); end
        n_cmp++; if (done_cyc.size() != 1) begin n_bad++; $display("FAIL b2b_done got %0d pulses want 1", done_cyc.size()); end
        n_cmp++; if (stab_err != 0) begin n_bad++; $display("FAIL b2b_stable got %0d changes want 0", stab_err); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 4'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
